// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Shares the register-file write port between execute writeback (requester 0)
// and load returns (requester 1). After reset it optionally zero-fills every
// register through the same port, then grants requests round-robin with a
// valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid/reg/data      execute writeback request
//   req0_ready               requester 0 accepted this cycle
//   req1_valid/reg/data      load-return writeback request
//   req1_ready               requester 1 accepted this cycle
//   wr_en, wr_reg, wr_data   registered register-file write port
//   init_done                registered, high once initialisation finished
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-fill in progress (or one idle edge when INIT_CLEAR=0)
// ST_RUN  | arbitrating writeback requests
module regfile_wport_arbiter #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [REG_W-1:0]  req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [REG_W-1:0]  req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [REG_W-1:0]  wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done
);

    // Highest register index, NREGS-1.
    localparam logic [REG_W-1:0] LAST_REG = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [REG_W-1:0]  init_cnt;
    logic [REG_W-1:0]  init_cnt_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic              grant0;
    logic              grant1;
    logic              wr_en_nxt;
    logic [REG_W-1:0]  wr_reg_nxt;
    logic [DATA_W-1:0] wr_data_nxt;
    logic              init_done_nxt;

    // State register and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;   // first tie after reset goes to requester 0
            wr_en      <= 1'b0;
            wr_reg     <= '0;
            wr_data    <= '0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            last_grant <= last_grant_nxt;
            wr_en      <= wr_en_nxt;
            wr_reg     <= wr_reg_nxt;
            wr_data    <= wr_data_nxt;
            init_done  <= init_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (!INIT_CLEAR || (init_cnt == LAST_REG)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Grant, handshake and next write-port values.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Ready is held low while rst is asserted, even before the reset edge
        // has pulled the state back to ST_INIT.
        if ((state == ST_RUN) && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        req0_ready = grant0;
        req1_ready = grant1;

        init_cnt_nxt   = init_cnt;
        last_grant_nxt = last_grant;
        wr_en_nxt      = 1'b0;
        wr_reg_nxt     = wr_reg;
        wr_data_nxt    = wr_data;
        init_done_nxt  = init_done;

        case (state)
            ST_INIT: begin
                init_done_nxt = !INIT_CLEAR || (init_cnt == LAST_REG);
                if (INIT_CLEAR) begin
                    wr_en_nxt    = 1'b1;
                    wr_reg_nxt   = init_cnt;
                    wr_data_nxt  = '0;
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (grant0) begin
                    wr_en_nxt      = 1'b1;
                    wr_reg_nxt     = req0_reg;
                    wr_data_nxt    = req0_data;
                    last_grant_nxt = 1'b0;
                end else if (grant1) begin
                    wr_en_nxt      = 1'b1;
                    wr_reg_nxt     = req1_reg;
                    wr_data_nxt    = req1_data;
                    last_grant_nxt = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Shares the single register-file write port of the 16-bit processor between two writeback sources: execute-stage results (requester 0) and load returns (requester 1). After reset it first runs an initialisation sequence that writes zero to every register through the same port. It then grants write requests round-robin using a valid/ready handshake. Its registered write-port outputs drive the register file's write enable, destination ID (decoded by the register file's write decoder) and write data.

## Interface
- DATA_W, 16, write data width
- REG_W, 4, register ID width; register count NREGS = 2**REG_W
- INIT_CLEAR, 1, 1 = zero-fill all registers after reset; 0 = skip straight to RUN
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  execute writeback request
- req0_reg  in  REG_W  destination register for requester 0
- req0_data  in  DATA_W  write data for requester 0
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid  in  1  load-return writeback request
- req1_reg  in  REG_W  destination register for requester 1
- req1_data  in  DATA_W  write data for requester 1
- req1_ready  out  1  requester 1 transfer accepted this cycle
- wr_en  out  1  register-file write enable (registered)
- wr_reg  out  REG_W  register-file destination ID (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- init_done  out  1  high once initialisation has finished (registered)

## Operation
- Reset is synchronous and active-high on clk: any rising edge with rst=1 sets state=INIT, init counter=0, last_grant=1, wr_en=0, wr_reg=0, wr_data=0, init_done=0.
- req*_ready is 0 while rst=1 and throughout INIT.
- State INIT (INIT_CLEAR=1): on each edge the block registers wr_en=1, wr_reg=counter, wr_data=0, then increments the counter.
  - On the edge that issues register NREGS-1, state moves to RUN and init_done is set to 1.
- INIT_CLEAR=0: the first edge with rst=0 moves state to RUN and sets init_done=1. No writes are issued.
- State RUN grant (combinational from valids and last_grant):
  - Exactly one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - None valid: no grant.
- req_i_ready = (state==RUN) & grant==i. At most one ready is high in any cycle.
- Transfer = valid & ready. On the transfer edge: wr_en=1, wr_reg/wr_data = the granted requester's reg/data, last_grant=i.
- With no transfer in RUN: wr_en=0, and wr_reg/wr_data hold their previous values.
- A requester keeps valid, reg and data stable until its ready is high. The block does not buffer, so an un-granted request simply waits.
- Both requesters targeting the same register: only the grantee writes this cycle. The other writes on a later cycle, so the later-granted data is what the register finally holds.
- Writes to register 0 are passed through unchanged; the register file decides what to do with them.

## Timing
- Latency from transfer edge to wr_en/wr_reg/wr_data visible: 1 edge (outputs registered). The register file captures the value on the following edge.
- Throughput: one write per cycle. Under sustained dual requests, grants alternate 0,1,0,1… First tie after reset goes to requester 0.
- INIT occupies exactly NREGS edges after reset release (16 for default).
  - The wr_en pulses for registers 0..15 appear after edges 1..16 following release.
  - init_done=1 and ready may first assert after edge 16.
- Reset asserted mid-INIT: the counter restarts at 0 and the full sequence reruns after release.
- Reset asserted mid-RUN: wr_en=0 after that edge and any in-flight grant is dropped. The requester must re-present, and it is not readied until after the new INIT.
- A valid arriving in the same cycle as the INIT→RUN transition edge is not granted in that cycle. The earliest grant is the cycle in which init_done reads 1.

## Test plan
- Reset release, INIT_CLEAR=1, no requests -> 16 consecutive cycles wr_en=1, wr_reg=0..15, wr_data=0x0000; then init_done=1, wr_en=0, both readies 0.
- After init, req0_valid=1, reg=3, data=0xBEEF for one cycle -> req0_ready=1 that cycle; next cycle wr_en=1, wr_reg=3, wr_data=0xBEEF; then wr_en=0.
- Both valid continuously (req0 reg=1 data=0x1111, req1 reg=2 data=0x2222) -> wr sequence reg1, reg2, reg1, reg2…, never two readies in the same cycle.
- Both valid, same reg=5, req0 data=0xAAAA, req1 data=0x5555 -> req0 granted first, req1 next; wr_data 0xAAAA then 0x5555 to reg 5.
- rst pulsed for 1 cycle at INIT count 7 -> wr_en=0 on the reset cycle, then a full 16-write sequence restarting at reg 0; init_done stays 0 until it completes.
- INIT_CLEAR=0, req1_valid held high through reset release -> no zero writes; req1_ready=1 in the cycle after the first post-reset edge; wr_en pulses one edge later.
